// File: rtl/nes_controller_responder_if.sv
// Host-link and status bundle for the NES controller responder.
// The master side drives buttons and the host lines; the responder is the slave.
interface nes_controller_responder_if;
  logic [7:0] buttons;
  logic       nes_latch;
  logic       nes_pulse;
  logic       nes_data;
  logic       busy;
  logic [3:0] bit_index;
  logic       frame_done;
  logic       timeout;

  modport master (
    output buttons, nes_latch, nes_pulse,
    input  nes_data, busy, bit_index, frame_done, timeout
  );

  modport slave (
    input  buttons, nes_latch, nes_pulse,
    output nes_data, busy, bit_index, frame_done, timeout
  );
endinterface

// File: rtl/nes_controller_responder.sv
// Device-side NES controller emulation: synchronizes host LATCH/CLOCK, snapshots the
// button vector on latch and shifts it out active-low, one bit per host clock rise.
module nes_controller_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                        clk,
  input logic                        rst_n,
  nes_controller_responder_if.slave  bus
);

  localparam int              WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  // Watchdog increment that parks at the timeout value instead of wrapping.
  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] latch_sync_p0;
  logic [SYNC_STAGES-1:0] pulse_sync_p0;
  logic                   latch_last_p1;
  logic                   pulse_last_p1;

  logic latch_rise;
  logic latch_fall;
  logic pulse_rise;

  state_t          state_q,  state_d;
  logic [7:0]      sr_q,     sr_d;
  logic [3:0]      idx_q,    idx_d;
  logic [WD_W-1:0] wd_q,     wd_d;
  logic [WD_W-1:0] wd_inc;
  logic            data_q,   data_d;
  logic            fd_q,     fd_d;
  logic            to_q,     to_d;

  // ---- p0: synchronizer chains; p1: edge-detect registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync_p0 <= '0;
      pulse_sync_p0 <= '0;
      latch_last_p1 <= 1'b0;
      pulse_last_p1 <= 1'b0;
    end else begin
      latch_sync_p0 <= {latch_sync_p0[SYNC_STAGES-2:0], bus.nes_latch};
      pulse_sync_p0 <= {pulse_sync_p0[SYNC_STAGES-2:0], bus.nes_pulse};
      latch_last_p1 <= latch_sync_p0[SYNC_STAGES-1];
      pulse_last_p1 <= pulse_sync_p0[SYNC_STAGES-1];
    end
  end

  assign latch_rise =  latch_sync_p0[SYNC_STAGES-1] & ~latch_last_p1;
  assign latch_fall = ~latch_sync_p0[SYNC_STAGES-1] &  latch_last_p1;
  assign pulse_rise =  pulse_sync_p0[SYNC_STAGES-1] & ~pulse_last_p1;

  // ---- p2: frame state, shift register and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= 8'hFF;
      idx_q   <= 4'd0;
      wd_q    <= '0;
      data_q  <= 1'b1;
      fd_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    fd_d    = 1'b0;
    to_d    = 1'b0;
    wd_inc  = wd_sat_inc(wd_q);

    // A latch rise restarts the frame from any state and outranks a coincident pulse.
    if (latch_rise) begin
      state_d = S_LOAD;
      sr_d    = bus.buttons;
      idx_d   = 4'd0;
      wd_d    = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (latch_fall) begin
            state_d = S_SHIFT;
            wd_d    = '0;
          end else begin
            sr_d = bus.buttons;
          end
        end
        S_SHIFT: begin
          if (pulse_rise) begin
            sr_d  = {1'b0, sr_q[7:1]};
            idx_d = idx_q + 4'd1;
            wd_d  = '0;
            if (idx_q == 4'd7) begin
              state_d = S_DONE;
              fd_d    = 1'b1;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            wd_d = wd_inc;
            if (wd_inc == WD_MAX) begin
              state_d = S_IDLE;
              idx_d   = 4'd0;
              wd_d    = '0;
              to_d    = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // DATA is registered alongside the state it reflects, so it is derived from next-state values.
    data_d = ((state_d == S_LOAD) || (state_d == S_SHIFT)) ? ~sr_d[0] : 1'b1;
  end

  assign bus.nes_data   = data_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bus.bit_index  = idx_q;
  assign bus.frame_done = fd_q;
  assign bus.timeout    = to_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Self-checking bench for nes_controller_responder with randomized button vectors
// and pulse widths compared against a frame-level model of the serial protocol.
module tb_nes_controller_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nes_controller_responder_if bus ();

  nes_controller_responder #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;
  int to_seen  = 0;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_seen++;
    if (bus.timeout === 1'b1)    to_seen++;
  end

  // Expected DATA level after 'shifted' bits have gone past: active-low button, then released.
  function automatic logic exp_data(input logic [7:0] btn, input int shifted);
    if (shifted >= 8) return 1'b1;
    return ~btn[shifted];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    bus.nes_pulse = 1'b1;
    cyc(hi);
    bus.nes_pulse = 1'b0;
    cyc(lo);
  endtask

  task automatic latch_frame(input logic [7:0] b, input int hi);
    bus.buttons   = b;
    bus.nes_latch = 1'b1;
    cyc(hi);
    bus.nes_latch = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_checks++; if (bus.nes_data !== 1'b1)     $display("FAIL reset_data: got %b want 1", bus.nes_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)         $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.bit_index !== 4'd0)    $display("FAIL reset_index: got %0d want 0", bus.bit_index); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0)   $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.timeout !== 1'b0)      $display("FAIL reset_timeout: got %b want 0", bus.timeout); else n_pass++;
    rst_n = 1'b1;
    cyc(4);
    n_checks++; if (bus.nes_data !== 1'b1)     $display("FAIL post_reset_data: got %b want 1", bus.nes_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)         $display("FAIL post_reset_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int fd0;
    b   = 8'b0000_0101;
    fd0 = fd_seen;
    latch_frame(b, 10);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", bus.busy); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.nes_data !== exp_data(b, i)) $display("FAIL basic_data[%0d]: got %b want %b", i, bus.nes_data, exp_data(b, i)); else n_pass++;
      n_checks++; if (bus.bit_index !== 4'(i)) $display("FAIL basic_index[%0d]: got %0d want %0d", i, bus.bit_index, i); else n_pass++;
      send_pulse(10, 10);
    end
    n_checks++; if (bus.nes_data !== 1'b1)  $display("FAIL basic_end_data: got %b want 1", bus.nes_data); else n_pass++;
    n_checks++; if (bus.bit_index !== 4'd8) $display("FAIL basic_end_index: got %0d want 8", bus.bit_index); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)      $display("FAIL basic_end_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (fd_seen - fd0 != 1)     $display("FAIL basic_frame_done_count: got %0d want 1", fd_seen - fd0); else n_pass++;
  endtask

  task automatic test_live_load();
    logic [7:0] seq [3];
    int fd0;
    seq[0] = 8'h00; seq[1] = 8'h80; seq[2] = 8'h01;
    fd0 = fd_seen;
    bus.nes_latch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.buttons = seq[k];
      cyc(6);
      n_checks++; if (bus.nes_data !== ~seq[k][0]) $display("FAIL live_track[%0d]: got %b want %b", k, bus.nes_data, ~seq[k][0]); else n_pass++;
    end
    bus.nes_latch = 1'b0;
    cyc(5);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.nes_data !== exp_data(8'h01, i)) $display("FAIL live_data[%0d]: got %b want %b", i, bus.nes_data, exp_data(8'h01, i)); else n_pass++;
      send_pulse(10, 10);
    end
    n_checks++; if (fd_seen - fd0 != 1) $display("FAIL live_frame_done_count: got %0d want 1", fd_seen - fd0); else n_pass++;
  endtask

  task automatic test_overclock();
    logic [7:0] b;
    int fd0;
    b   = 8'($urandom);
    fd0 = fd_seen;
    latch_frame(b, 8);
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (bus.nes_data !== exp_data(b, i)) $display("FAIL over_data[%0d]: got %b want %b", i, bus.nes_data, exp_data(b, i)); else n_pass++;
      n_checks++; if (bus.bit_index !== 4'((i > 8) ? 8 : i)) $display("FAIL over_index[%0d]: got %0d want %0d", i, bus.bit_index, (i > 8) ? 8 : i); else n_pass++;
      send_pulse(10, 10);
    end
    n_checks++; if (bus.bit_index !== 4'd8) $display("FAIL over_end_index: got %0d want 8", bus.bit_index); else n_pass++;
    n_checks++; if (fd_seen - fd0 != 1)     $display("FAIL over_frame_done_count: got %0d want 1", fd_seen - fd0); else n_pass++;
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    int fd0, hi, lo;
    fd0 = fd_seen;
    for (int f = 0; f < 8; f++) begin
      b = 8'($urandom);
      latch_frame(b, $urandom_range(3, 12));
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (bus.nes_data !== exp_data(b, i)) $display("FAIL rand_data[f%0d b%0d]: got %b want %b", f, i, bus.nes_data, exp_data(b, i)); else n_pass++;
        hi = $urandom_range(SYNC + 1, 8);
        lo = $urandom_range(SYNC + 1, 8);
        send_pulse(hi, lo);
      end
      n_checks++; if (bus.bit_index !== 4'd8) $display("FAIL rand_end_index[f%0d]: got %0d want 8", f, bus.bit_index); else n_pass++;
    end
    cyc(5);
    n_checks++; if (fd_seen - fd0 != 8) $display("FAIL rand_frame_done_count: got %0d want 8", fd_seen - fd0); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    int to0, fd0;
    b   = 8'($urandom);
    to0 = to_seen;
    fd0 = fd_seen;
    latch_frame(b, 8);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (bus.nes_data !== exp_data(b, i)) $display("FAIL tmo_data[%0d]: got %b want %b", i, bus.nes_data, exp_data(b, i)); else n_pass++;
      send_pulse(10, 10);
    end
    // Third pulse is acted on SYNC+1 edges after it is driven; the timeout follows TMO edges later.
    bus.nes_pulse = 1'b1;
    cyc(5);
    bus.nes_pulse = 1'b0;
    cyc(SYNC + TMO - 5);
    n_checks++; if (bus.timeout !== 1'b0)           $display("FAIL tmo_early: got %b want 0", bus.timeout); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1)              $display("FAIL tmo_busy_before: got %b want 1", bus.busy); else n_pass++;
    n_checks++; if (bus.bit_index !== 4'd3)         $display("FAIL tmo_index_before: got %0d want 3", bus.bit_index); else n_pass++;
    n_checks++; if (bus.nes_data !== exp_data(b, 3)) $display("FAIL tmo_data_before: got %b want %b", bus.nes_data, exp_data(b, 3)); else n_pass++;
    cyc(1);
    n_checks++; if (bus.timeout !== 1'b1)   $display("FAIL tmo_pulse: got %b want 1", bus.timeout); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)      $display("FAIL tmo_busy_after: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.nes_data !== 1'b1)  $display("FAIL tmo_data_after: got %b want 1", bus.nes_data); else n_pass++;
    n_checks++; if (bus.bit_index !== 4'd0) $display("FAIL tmo_index_after: got %0d want 0", bus.bit_index); else n_pass++;
    cyc(1);
    n_checks++; if (bus.timeout !== 1'b0)   $display("FAIL tmo_one_cycle: got %b want 0", bus.timeout); else n_pass++;
    cyc(3);
    n_checks++; if (to_seen - to0 != 1)     $display("FAIL tmo_count: got %0d want 1", to_seen - to0); else n_pass++;
    n_checks++; if (fd_seen != fd0)         $display("FAIL tmo_no_frame_done: got %0d want %0d", fd_seen, fd0); else n_pass++;
  endtask

  task automatic test_relatch();
    logic [7:0] b1, b2;
    int fd0, to0;
    b1 = 8'($urandom);
    b2 = 8'($urandom) ^ 8'h01;
    if (b2[0] == b1[4]) b2[0] = ~b2[0];
    latch_frame(b1, 8);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.nes_data !== exp_data(b1, i)) $display("FAIL relatch_data1[%0d]: got %b want %b", i, bus.nes_data, exp_data(b1, i)); else n_pass++;
      send_pulse(10, 10);
    end
    fd0 = fd_seen;
    to0 = to_seen;
    bus.buttons   = b2;
    bus.nes_latch = 1'b1;
    bus.nes_pulse = 1'b1;
    cyc(SYNC);
    n_checks++; if (bus.bit_index !== 4'd4) $display("FAIL relatch_latency: got %0d want 4", bus.bit_index); else n_pass++;
    cyc(1);
    n_checks++; if (bus.bit_index !== 4'd0)  $display("FAIL relatch_index: got %0d want 0", bus.bit_index); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1)       $display("FAIL relatch_busy: got %b want 1", bus.busy); else n_pass++;
    n_checks++; if (bus.nes_data !== ~b2[0]) $display("FAIL relatch_load_data: got %b want %b", bus.nes_data, ~b2[0]); else n_pass++;
    cyc(5);
    bus.nes_pulse = 1'b0;
    cyc(5);
    n_checks++; if (bus.bit_index !== 4'd0) $display("FAIL relatch_pulse_ignored: got %0d want 0", bus.bit_index); else n_pass++;
    n_checks++; if (fd_seen != fd0 || to_seen != to0) $display("FAIL relatch_no_strobe: got fd=%0d to=%0d want fd=%0d to=%0d", fd_seen, to_seen, fd0, to0); else n_pass++;
    bus.nes_latch = 1'b0;
    cyc(5);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.nes_data !== exp_data(b2, i)) $display("FAIL relatch_data2[%0d]: got %b want %b", i, bus.nes_data, exp_data(b2, i)); else n_pass++;
      send_pulse(10, 10);
    end
    n_checks++; if (fd_seen - fd0 != 1) $display("FAIL relatch_frame_done_count: got %0d want 1", fd_seen - fd0); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    b = 8'($urandom) | 8'h08;
    latch_frame(b, 8);
    for (int i = 0; i < 3; i++) send_pulse(10, 10);
    n_checks++; if (bus.nes_data !== 1'b0)  $display("FAIL areset_pre_data: got %b want 0", bus.nes_data); else n_pass++;
    n_checks++; if (bus.bit_index !== 4'd3) $display("FAIL areset_pre_index: got %0d want 3", bus.bit_index); else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.nes_data !== 1'b1)  $display("FAIL areset_data: got %b want 1", bus.nes_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)      $display("FAIL areset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.bit_index !== 4'd0) $display("FAIL areset_index: got %0d want 0", bus.bit_index); else n_pass++;
    @(negedge clk);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      send_pulse(10, 10);
      n_checks++; if (bus.nes_data !== 1'b1)  $display("FAIL areset_idle_data[%0d]: got %b want 1", i, bus.nes_data); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0)      $display("FAIL areset_idle_busy[%0d]: got %b want 0", i, bus.busy); else n_pass++;
      n_checks++; if (bus.bit_index !== 4'd0) $display("FAIL areset_idle_index[%0d]: got %0d want 0", i, bus.bit_index); else n_pass++;
    end
  endtask

  initial begin
    bus.buttons   = 8'h00;
    bus.nes_latch = 1'b0;
    bus.nes_pulse = 1'b0;
    test_reset();
    test_basic();
    test_live_load();
    test_overclock();
    test_random_frames();
    test_timeout();
    test_relatch();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/nes_controller_responder.md
# nes_controller_responder

Device-side end of the NES controller serial link: emulates the controller's parallel-in/serial-out shift register so our FPGA can stand in for a physical gamepad. It samples the host's LATCH and CLOCK lines, snapshots an 8-bit button vector on latch, and drives the active-low DATA line one button per host clock pulse. It sits between on-board button/stimulus logic and the controller connector pins; all host lines are asynchronous to `clk`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on each host input; minimum 2.
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles allowed between latch fall and the 8th pulse; 0 disables the timeout.

- `clk`  in  1  system clock; the block has exactly one clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `buttons`  in  8  button state, 1 = pressed; bit 0 is sent first.
- `nes_latch`  in  1  host LATCH line, asynchronous, active-high.
- `nes_pulse`  in  1  host CLOCK line, asynchronous; a rising edge advances one bit.
- `nes_data`  out  1  serial DATA to host, active-low: 0 = pressed.
- `busy`  out  1  high in LOAD and SHIFT.
- `bit_index`  out  4  number of bits already shifted past, 0..8.
- `frame_done`  out  1  one-cycle pulse when the 8th shift completes.
- `timeout`  out  1  one-cycle pulse when SHIFT is abandoned.

## Operation
- Each host input passes through `SYNC_STAGES` flops, then one edge-detect register. Rise and fall strobes derive from the last two synchronized samples.
- The shift register `sr[7:0]` is internal. `nes_data` is registered and always equals `~sr[0]` in LOAD and SHIFT, and 1 otherwise.
- States:
  - **IDLE**: `nes_data` = 1, `bit_index` = 0. Latch rise → LOAD.
  - **LOAD**: `sr` <= `buttons` every cycle, so the value tracks live buttons while latch is high. `bit_index` = 0. Pulse edges are ignored. Latch fall → SHIFT; the `sr` value from the final LOAD cycle is kept.
  - **SHIFT**: on pulse rise, `sr` <= {1'b0, `sr`[7:1]} and `bit_index`++. The 0 fill drives DATA high, meaning "released".
    - When `bit_index` becomes 8 → DONE, with `frame_done` pulsed in the same cycle.
    - Watchdog counter counts cycles since entering SHIFT and resets on each pulse rise. When it reaches `TIMEOUT_CYCLES` → IDLE, with `timeout` pulsed.
  - **DONE**: `nes_data` = 1, `bit_index` holds at 8. Further pulses are ignored. Latch rise → LOAD.
- Latch rise in any state forces LOAD, clears `bit_index`, and clears the watchdog.
  - A latch rise in the same cycle as a pulse rise: the latch wins and no shift occurs.
  - A latch rise in SHIFT aborts the frame without `frame_done` or `timeout`.
- Latch fall while in IDLE or DONE (a glitch, or a latch fall with no preceding rise) is ignored.
- Extra pulses beyond 8 never wrap `bit_index` and never re-expose old bits.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1), and the counter saturates.

## Timing
- Reset values: state IDLE, `nes_data` 1, `busy` 0, `bit_index` 0, `frame_done` 0, `timeout` 0, `sr` 8'hFF, all synchronizer flops 0.
- Input-to-action latency is `SYNC_STAGES`+1 `clk` rising edges after the first edge that samples the new pin level; with the default this is 3 edges.
- `nes_data` for bit 0 (`buttons[0]`) is valid from the first LOAD cycle onward.
- `nes_data` updates in the same edge as the state or shift change it reflects; there is no extra output stage.
- Host pulse high and low times must each be at least `SYNC_STAGES`+1 `clk` periods for guaranteed detection; narrower pulses may be dropped.
- Reset asserted mid-frame returns every output to its reset value immediately, not waiting for a clock edge. After deassertion the block waits for a fresh latch rise.

## Test plan
1. **Basic frame.** Reset; `buttons`=8'b0000_0101; latch high 10 cycles then low; 8 pulses at 20-cycle period.
   - DATA sequence sampled before each pulse must be 0,1,0,1,1,1,1,1.
   - After the 8th pulse: DATA=1, `bit_index`=8, and exactly one `frame_done` pulse.
2. **Live load.** While latch is high, change `buttons` 8'h00 → 8'h80 → 8'h01.
   - DATA follows `~buttons[0]`.
   - After latch falls with 8'h01 loaded, the 1st bit is 0 and the rest are 1.
3. **Over-clock.** Send 12 pulses after latch.
   - Pulses 9–12 give DATA=1, `bit_index` stays 8, and `frame_done` fires only once.
4. **Timeout.** With `TIMEOUT_CYCLES`=50, send a latch then 3 pulses, then stop.
   - `timeout` pulses 50 cycles after the 3rd pulse is detected.
   - State returns to IDLE with `busy`=0, DATA=1, `bit_index`=0.
5. **Re-latch mid-frame.** Raise latch after 4 pulses, in the same sync cycle as a pulse rise.
   - State enters LOAD and `bit_index`=0.
   - No shift occurs, and neither `frame_done` nor `timeout` fires.
6. **Async reset.** Assert `rst_n`=0 mid-SHIFT between clock edges.
   - Outputs go to reset values without a clock edge.
   - After release, pulses alone leave DATA=1.
